cond_flags_seq: RTL and testbench
=================================

Name: cond_flags_seq

Overview:
Registered condition-code unit, successor to the combinational condition evaluator. Holds the NCZV flag register. Evaluates each instruction's 4-bit condition against the registered flags. Adds a parametrised IT-block sequencer that predicates up to IT_MAX following instructions with then/else conditions. Sits between decode and writeback; exec_en gates register and flag writes.

Parameters:
IT_MAX, 4, maximum number of instructions in one IT block (1..8)
CW, $clog2(IT_MAX+1), width of the IT length/count fields (derived, do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  an instruction is at the evaluate stage this cycle
cond_in  in  4  instruction condition field (used only when IT idle)
set_flags  in  1  instruction requests flag update (S bit)
alu_flags  in  4  ALU result flags, order NCZV ([3]=N,[2]=C,[1]=Z,[0]=V)
it_start  in  1  load an IT block this cycle
it_cond  in  4  IT base condition
it_mask  in  IT_MAX  per-slot then(1)/else(0); bit0 = first instruction
it_len  in  CW  number of instructions in block
flush  in  1  pipeline flush; abort IT block
flags_q  out  4  registered NCZV flags
exec_en  out  1  current instruction executes (combinational)
it_active  out  1  IT block in progress (registered)
it_count  out  CW  slots remaining (registered)
err_it  out  1  one-cycle pulse: illegal IT request (registered)

Behaviour:
- Async reset (rst_n low): flags_q=0, it_active=0, it_count=0, err_it=0, FSM=IDLE. The mask and condition registers reset to 0. A reset mid-block drops the block immediately.
- Condition truth, over flags_q:
  - 0000 EQ=Z; 0001 NE=~Z
  - 0010 CS=C; 0011 CC=~C
  - 0100 MI=N; 0101 PL=~N
  - 0110 VS=V; 0111 VC=~V
  - 1000 HI=C&~Z; 1001 LS=~C|Z
  - 1010 GE=~(N^V); 1011 LT=N^V
  - 1100 GT=~Z&~(N^V); 1101 LE=Z|(N^V)
  - 1110 AL=1; 1111=1
- Effective condition eff:
  - IDLE: eff = cond_in.
  - ACTIVE: eff = {cond_r[3:1], cond_r[0] ^ ~mask_r[0]}. An else slot inverts an even/odd pair. An AL base stays always-true in both then and else slots.
- exec_en = instr_valid & truth(eff). It is purely combinational from flags_q and the state registers. There is no bypass: flags written by instruction i are visible to i+1 on the next cycle.
- Flag update at posedge: if instr_valid & set_flags & exec_en, then flags_q <= alu_flags; otherwise hold. Flush does not block the flag update.
- FSM IDLE:
  - it_start with 1<=it_len<=IT_MAX: cond_r<=it_cond, mask_r<=it_mask, it_count<=it_len, go ACTIVE. The cycle carrying it_start is the IT setup instruction; it is evaluated by cond_in as normal.
  - it_start with it_len=0 or >IT_MAX: stay IDLE, err_it=1 for one cycle.
- FSM ACTIVE, on each instr_valid:
  - Consume one slot: it_count-1, mask_r shifted right by 1 with zero fill.
  - If it_count was 1, go IDLE (it_count=0).
  - Without instr_valid, hold all state (stall).
- it_start while ACTIVE: ignored, err_it pulses. A simultaneous instr_valid still consumes a slot.
- flush (priority over everything in the IT FSM): next state IDLE, it_count=0, it_active=0. This includes the case of it_start in the same cycle, which is dropped with no err_it. exec_en for the flush cycle is still computed from the pre-flush state.
- it_active = (state==ACTIVE). err_it is otherwise 0.

Test Plan:
- Reset then instr_valid, cond_in=0000, with flags_q=0 -> exec_en=0; with cond_in=1110 -> exec_en=1, flags_q=0000.
- Flag pipeline: cycle0 set_flags=1, cond=AL, alu_flags=0010 -> flags_q=0010 at cycle1. Cycle1 cond=EQ -> exec_en=1; NE -> 0; GT -> 0; LE -> 1.
- Predicated flag write: flags_q=0000, cond=EQ, set_flags=1, alu_flags=1111 -> exec_en=0, flags_q stays 0000.
- IT block: flags_q=0010 (Z), it_start, it_cond=0000, it_len=3, it_mask=...101.
  - Three instr_valid -> exec_en=1,0,1; it_count 3,2,1 then 0; it_active falls after the third.
  - A stall cycle inserted mid-block holds it_count.
- Illegal and nested starts:
  - it_len=0 in IDLE -> err_it=1 for one cycle, it_active=0.
  - it_len=5 with IT_MAX=4 -> err_it=1, it_active=0.
  - it_start during ACTIVE with instr_valid -> err_it=1, count decrements, original cond/mask kept.
- Flush and reset:
  - flush at it_count=2 -> next cycle it_active=0, it_count=0, following instructions use cond_in.
  - rst_n low mid-block -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cond_flags_seq.sv
// Registered NCZV condition-code unit with an IT-block sequencer that
// predicates up to IT_MAX following instructions with then/else conditions.
module cond_flags_seq #(
  parameter  int unsigned IT_MAX = 4,
  localparam int unsigned CW     = $clog2(IT_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [3:0]        cond_in,
  input  logic              set_flags,
  input  logic [3:0]        alu_flags,
  input  logic              it_start,
  input  logic [3:0]        it_cond,
  input  logic [IT_MAX-1:0] it_mask,
  input  logic [CW-1:0]     it_len,
  input  logic              flush,
  output logic [3:0]        flags_q,
  output logic              exec_en,
  output logic              it_active,
  output logic [CW-1:0]     it_count,
  output logic              err_it
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cond_r, cond_d;
  logic [IT_MAX-1:0]   mask_r, mask_d;
  logic [CW-1:0]       count_d;
  logic                err_d;
  logic [3:0]          eff_cond;
  logic                len_ok;

  // Condition truth table over NCZV ([3]=N,[2]=C,[1]=Z,[0]=V)
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, cf, z, v;
    n  = f[3];
    cf = f[2];
    z  = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_true = z;
      4'b0001: cond_true = ~z;
      4'b0010: cond_true = cf;
      4'b0011: cond_true = ~cf;
      4'b0100: cond_true = n;
      4'b0101: cond_true = ~n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = ~v;
      4'b1000: cond_true = cf & ~z;
      4'b1001: cond_true = ~cf | z;
      4'b1010: cond_true = ~(n ^ v);
      4'b1011: cond_true = n ^ v;
      4'b1100: cond_true = ~z & ~(n ^ v);
      4'b1101: cond_true = z | (n ^ v);
      default: cond_true = 1'b1;
    endcase
  endfunction

  // An else slot flips the low bit, selecting the complementary condition
  always_comb begin
    eff_cond = cond_in;
    if (state_q == ACTIVE) begin
      eff_cond = {cond_r[3:1], cond_r[0] ^ ~mask_r[0]};
    end
  end

  assign exec_en   = instr_valid & cond_true(eff_cond, flags_q);
  assign it_active = (state_q == ACTIVE);
  assign len_ok    = (it_len != '0) && (it_len <= CW'(IT_MAX));

  // Flag register: predicated by exec_en, not blocked by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (instr_valid && set_flags && exec_en) begin
      flags_q <= alu_flags;
    end
  end

  // IT sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cond_r   <= 4'b0000;
      mask_r   <= '0;
      it_count <= '0;
      err_it   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cond_r   <= cond_d;
      mask_r   <= mask_d;
      it_count <= count_d;
      err_it   <= err_d;
    end
  end

  // IT sequencer next state; flush overrides everything including it_start
  always_comb begin
    state_d = state_q;
    cond_d  = cond_r;
    mask_d  = mask_r;
    count_d = it_count;
    err_d   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (it_start) begin
            if (len_ok) begin
              state_d = ACTIVE;
              cond_d  = it_cond;
              mask_d  = it_mask;
              count_d = it_len;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ACTIVE: begin
          err_d = it_start;
          if (instr_valid) begin
            mask_d = mask_r >> 1;
            if (it_count == CW'(1)) begin
              state_d = IDLE;
              count_d = '0;
            end else begin
              count_d = it_count - CW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_flags_seq.sv
// Scoreboard bench for cond_flags_seq: each driven cycle queues its expected
// exec_en and post-edge register values; a monitor pops and compares them.
module tb_cond_flags_seq;

  localparam int unsigned IT_MAX = 4;
  localparam int unsigned CW     = 3;

  logic              clk;
  logic              rst_n;
  logic              instr_valid;
  logic [3:0]        cond_in;
  logic              set_flags;
  logic [3:0]        alu_flags;
  logic              it_start;
  logic [3:0]        it_cond;
  logic [IT_MAX-1:0] it_mask;
  logic [CW-1:0]     it_len;
  logic              flush;
  logic [3:0]        flags_q;
  logic              exec_en;
  logic              it_active;
  logic [CW-1:0]     it_count;
  logic              err_it;

  cond_flags_seq #(.IT_MAX(IT_MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .cond_in     (cond_in),
    .set_flags   (set_flags),
    .alu_flags   (alu_flags),
    .it_start    (it_start),
    .it_cond     (it_cond),
    .it_mask     (it_mask),
    .it_len      (it_len),
    .flush       (flush),
    .flags_q     (flags_q),
    .exec_en     (exec_en),
    .it_active   (it_active),
    .it_count    (it_count),
    .err_it      (err_it)
  );

  typedef struct {
    string      tag;
    logic       ex;
    logic [3:0] fl;
    logic       act;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic ex_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge and queue what it must produce
  task automatic step(input string tag, input bit iv, input bit [3:0] c,
                      input bit sf, input bit [3:0] alu, input bit its,
                      input bit [3:0] itc, input bit [3:0] itm, input bit [2:0] itl,
                      input bit fl, input bit ex, input bit [3:0] ef,
                      input bit act, input bit [2:0] cnt, input bit err);
    exp_t e;
    @(negedge clk);
    instr_valid = iv;
    cond_in     = c;
    set_flags   = sf;
    alu_flags   = alu;
    it_start    = its;
    it_cond     = itc;
    it_mask     = itm;
    it_len      = itl;
    flush       = fl;
    e.tag = tag; e.ex = ex; e.fl = ef; e.act = act; e.cnt = cnt; e.err = err;
    sb.push_back(e);
  endtask

  // Monitor: exec_en sampled late in the low phase, registers just after the edge
  always begin
    exp_t r;
    @(negedge clk);
    #3 ex_s = exec_en;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({r.tag, ".exec_en"},   32'(ex_s),      32'(r.ex));
      chk({r.tag, ".flags_q"},   32'(flags_q),   32'(r.fl));
      chk({r.tag, ".it_active"}, 32'(it_active), 32'(r.act));
      chk({r.tag, ".it_count"},  32'(it_count),  32'(r.cnt));
      chk({r.tag, ".err_it"},    32'(err_it),    32'(r.err));
    end
  end

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0; cond_in = 4'h0; set_flags = 1'b0; alu_flags = 4'h0;
    it_start = 1'b0; it_cond = 4'h0; it_mask = '0; it_len = '0; flush = 1'b0;
    #1;
    chk("rst.flags_q",   32'(flags_q),   32'h0);
    chk("rst.it_active", 32'(it_active), 32'h0);
    chk("rst.it_count",  32'(it_count),  32'h0);
    chk("rst.err_it",    32'(err_it),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //    tag       iv  cond     sf  alu      its itc      itm      itl fl   ex  flags   act cnt err
    step("eq0",     1, 4'b0000, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0000, 0, 0, 0);
    step("al0",     1, 4'b1110, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0000, 0, 0, 0);
    step("setz",    1, 4'b1110, 1, 4'b0010, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 0, 0, 0);
    step("eq",      1, 4'b0000, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 0, 0, 0);
    step("ne",      1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    step("gt",      1, 4'b1100, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    step("le",      1, 4'b1101, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 0, 0, 0);
    step("cs",      1, 4'b0010, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    step("hi",      1, 4'b1000, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    step("ls",      1, 4'b1001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 0, 0, 0);
    step("lt",      1, 4'b1011, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    step("ge",      1, 4'b1010, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 0, 0, 0);
    step("clr",     1, 4'b1110, 1, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0000, 0, 0, 0);
    step("pred",    1, 4'b0000, 1, 4'b1111, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0000, 0, 0, 0);
    step("noiv",    0, 4'b1110, 1, 4'b1111, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0000, 0, 0, 0);
    step("setnv",   1, 4'b1110, 1, 4'b1001, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b1001, 0, 0, 0);
    step("nv_ge",   1, 4'b1010, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b1001, 0, 0, 0);
    step("nv_mi",   1, 4'b0100, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b1001, 0, 0, 0);
    step("nv_pl",   1, 4'b0101, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b1001, 0, 0, 0);
    step("nv_vs",   1, 4'b0110, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b1001, 0, 0, 0);
    step("nv_vc",   1, 4'b0111, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b1001, 0, 0, 0);
    step("nv_gt",   1, 4'b1100, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b1001, 0, 0, 0);
    step("setz2",   1, 4'b1110, 1, 4'b0010, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 0, 0, 0);
    // IT EQ, mask then/else/then, with a stall mid-block
    step("its",     1, 4'b1110, 0, 4'b0000, 1, 4'b0000, 4'b0101, 3, 0,   1, 4'b0010, 1, 3, 0);
    step("s0",      1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 1, 2, 0);
    step("stall",   0, 4'b1110, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 1, 2, 0);
    step("s1",      1, 4'b1110, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 1, 1, 0);
    step("s2",      1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 0, 0, 0);
    step("post",    1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    // Illegal lengths
    step("len0",    0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 4'b1111, 0, 0,   0, 4'b0010, 0, 0, 1);
    step("errclr",  0, 4'b0000, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    step("len5",    0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 4'b1111, 5, 0,   0, 4'b0010, 0, 0, 1);
    step("errclr2", 0, 4'b0000, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    // Nested start while active is ignored but still consumes a slot
    step("its2",    1, 4'b1110, 0, 4'b0000, 1, 4'b0000, 4'b0001, 2, 0,   1, 4'b0010, 1, 2, 0);
    step("nest",    1, 4'b0001, 0, 4'b0000, 1, 4'b0001, 4'b1111, 4, 0,   1, 4'b0010, 1, 1, 1);
    step("n1",      1, 4'b1110, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    // AL base stays true in else slots
    step("ital",    1, 4'b1110, 0, 4'b0000, 1, 4'b1110, 4'b0000, 2, 0,   1, 4'b0010, 1, 2, 0);
    step("a0",      1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 1, 1, 0);
    step("a1",      1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 0, 0, 0);
    // Flush mid-block, flush with start, flush with flag write
    step("itf",     1, 4'b1110, 0, 4'b0000, 1, 4'b0000, 4'b1111, 4, 0,   1, 4'b0010, 1, 4, 0);
    step("f0",      1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 1, 3, 0);
    step("f1",      1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   1, 4'b0010, 1, 2, 0);
    step("fl",      1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 1,   1, 4'b0010, 0, 0, 0);
    step("pf",      1, 4'b0001, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0010, 0, 0, 0);
    step("flst",    0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 4'b1111, 2, 1,   0, 4'b0010, 0, 0, 0);
    step("flf",     1, 4'b1110, 1, 4'b0100, 0, 4'h0,    4'b0000, 0, 1,   1, 4'b0100, 0, 0, 0);
    // Block left running for the asynchronous reset check
    step("itr",     1, 4'b1110, 0, 4'b0000, 1, 4'b0000, 4'b0111, 3, 0,   1, 4'b0100, 1, 3, 0);

    @(posedge clk);
    #2;
    instr_valid = 1'b0; set_flags = 1'b0; it_start = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst.flags_q",   32'(flags_q),   32'h0);
    chk("arst.it_active", 32'(it_active), 32'h0);
    chk("arst.it_count",  32'(it_count),  32'h0);
    chk("arst.err_it",    32'(err_it),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("after",   1, 4'b0000, 0, 4'b0000, 0, 4'h0,    4'b0000, 0, 0,   0, 4'b0000, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
